// File: rtl/pixel_fetch_initiator.sv
// Arbiter-channel read client: fetches byte_count bytes from base_addr via req/rdy and
// streams them out over valid/ready. Define PIXEL_FETCH_PREFETCH_EN for a 2-entry output FIFO.
`timescale 1ns/1ps
module pixel_fetch_initiator #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int COUNT_WIDTH   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]   byte_count,
  output logic                     busy,
  output logic                     done,
  output logic                     data_req,
  output logic [ADDRESS_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_rdy,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [2:0] {IDLE, REQ, RELEASE, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     req_q, req_d;
  logic                     start_ok, capture, pop, slot_free, buf_empty;

  // A start coinciding with the visible done pulse is dropped along with starts while busy.
  assign start_ok = start && !done_q;
  assign capture  = (state_q == REQ) && data_rdy;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = (byte_count == '0) ? DONE : REQ;
      REQ:     if (data_rdy) state_d = RELEASE;
      RELEASE: begin
        // Re-requesting while rdy is still high would return the previous byte.
        if (!data_rdy) begin
          if (remaining_q == '0) state_d = DRAIN;
          else if (slot_free)    state_d = REQ;
        end
      end
      DRAIN:   if (buf_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = (state_q == DONE);
    req_d       = (state_d == REQ);
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          addr_d      = base_addr;
          remaining_d = byte_count;
          busy_d      = 1'b1;
        end
      end
      REQ:     if (data_rdy) remaining_d = remaining_q - 1'b1;
      RELEASE: if (state_d == REQ) addr_d = addr_q + 1'b1;
      DONE:    busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_q       <= req_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data_req  = req_q;
  assign data_addr = addr_q;

`ifdef PIXEL_FETCH_PREFETCH_EN
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            fill_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (rst)                                 fifo_q[gi] <= '0;
      else if (capture && (wr_ptr_q == 1'(gi))) fifo_q[gi] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
    end else begin
      if (capture) wr_ptr_q <= ~wr_ptr_q;
      if (pop)     rd_ptr_q <= ~rd_ptr_q;
      case ({capture, pop})
        2'b10:   fill_q <= fill_q + 2'd1;
        2'b01:   fill_q <= fill_q - 2'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Next fetch may start while one byte is still waiting for the serializer.
  assign slot_free = (fill_q != 2'd2) || pop;
  assign buf_empty = (fill_q == 2'd0);
  assign out_valid = (fill_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_data_q  <= data_in;
      out_valid_q <= 1'b1;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  assign buf_empty = !out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`endif

endmodule

// File: tb/tb_pixel_fetch_initiator.sv
// Directed bench for pixel_fetch_initiator: frame table plus reset and restart sequences,
// with a single-channel arbiter model (mem[a] = a ^ 0xA5) and a stallable serializer.
`timescale 1ns/1ps
module tb_pixel_fetch_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [9:0] byte_count = 10'd0;
  logic       busy, done, data_req;
  logic [7:0] data_addr;
  logic [7:0] data_in = 8'hEE;
  logic       data_rdy = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  pixel_fetch_initiator dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_count(byte_count),
    .busy(busy), .done(done), .data_req(data_req), .data_addr(data_addr),
    .data_in(data_in), .data_rdy(data_rdy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0]  base;
    logic [9:0]  count;
    int          hold;     // arbiter cycles stolen by a higher-priority channel
    int          stall;    // out_ready low cycles once the first byte is valid
    int          lat;      // expected start-to-done cycles, -1 = unchecked
    bit          restart;  // pulse start again mid-frame
    bit          sad;      // pulse start during the done pulse
    int          n;
    logic [31:0] addrs;    // expected addresses, first in [7:0]
    logic [31:0] datas;    // expected bytes, first in [7:0]
  } vec_t;

  vec_t vecs [7];
  int   n_cmp = 0, n_bad = 0;

  logic [7:0] addr_log [$];
  logic [7:0] data_log [$];
  int  done_cnt = 0, hs_total = 0, hold_left = 0, stall_left = 0, arb_cnt = 0, reqs_in_stall = 0;
  int  v_addr = 0, v_hs = 0, v_hold = 0;
  bit  stall_on = 0, req_p = 0, valid_p = 0, ready_p = 1, rst_p = 1;
  logic [7:0] addr_p = 8'h00, data_p = 8'h00;

  function automatic vec_t mk(input logic [7:0] base, input logic [9:0] count, input int hold,
                              input int stall, input int lat, input bit restart, input bit sad,
                              input int n, input logic [31:0] addrs, input logic [31:0] datas);
    vec_t v;
    v.base = base; v.count = count; v.hold = hold; v.stall = stall; v.lat = lat;
    v.restart = restart; v.sad = sad; v.n = n; v.addrs = addrs; v.datas = datas;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Protocol monitor, arbiter model and serializer model, all evaluated between edges.
  always @(negedge clk) begin
    if (!rst && !rst_p) begin
      if (req_p && data_req && data_addr != addr_p) v_addr++;
      if (data_req && !req_p && data_rdy) v_hs++;
      if (req_p && !data_req && !data_rdy) v_hs++;
      if (valid_p && !ready_p && (!out_valid || out_data != data_p)) v_hold++;
    end
    if (data_req && !req_p) begin
      addr_log.push_back(data_addr);
      if (stall_on) reqs_in_stall++;
    end
    if (done) done_cnt++;

    if (!data_req) begin
      data_rdy = 1'b0; arb_cnt = 0; data_in = 8'hEE;
    end else if (!data_rdy) begin
      if (hold_left > 0) hold_left--;
      else if (arb_cnt == 1) begin data_rdy = 1'b1; data_in = data_addr ^ 8'hA5; end
      else arb_cnt++;
    end

    if (!stall_on && stall_left > 0 && out_valid) stall_on = 1;
    if (stall_on) begin
      out_ready = 1'b0;
      stall_left--;
      if (stall_left == 0) stall_on = 0;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid && out_ready) begin
      data_log.push_back(out_data);
      hs_total++;
    end

    req_p = data_req; addr_p = data_addr; valid_p = out_valid;
    ready_p = out_ready; data_p = out_data; rst_p = rst;
  end

  task automatic run_frame(input vec_t v, input int idx);
    int cyc;
    bit got, busy_drop;
    int d0, a0, h0, s0;
    addr_log.delete(); data_log.delete();
    d0 = done_cnt; a0 = v_addr; h0 = v_hs; s0 = v_hold;
    hold_left = v.hold; stall_left = v.stall; reqs_in_stall = 0;
    base_addr = v.base; byte_count = v.count; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~v.base; byte_count = 10'd9;
    chk($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);
    got = 0; busy_drop = 0; cyc = 2;
    while (cyc <= 3000 && !got) begin
      if (v.restart && cyc == 3) begin start = 1'b1; base_addr = 8'h00; byte_count = 10'd7; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) got = 1;
      else begin
        if (!busy) busy_drop = 1;
        cyc++;
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
    if (v.lat >= 0) chk($sformatf("v%0d done_latency", idx), 32'(cyc), 32'(v.lat));
    chk($sformatf("v%0d busy_held", idx), 32'(busy_drop), 32'd0);
    chk($sformatf("v%0d busy_at_done", idx), 32'(busy), 32'd0);
    if (v.sad) begin start = 1'b1; base_addr = 8'h77; byte_count = 10'd1; end
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("v%0d idle_after", idx), 32'({busy, data_req}), 32'd0);
    chk($sformatf("v%0d done_count", idx), 32'(done_cnt - d0), 32'd1);
    chk($sformatf("v%0d n_addr", idx), 32'(addr_log.size()), 32'(v.n));
    for (int i = 0; i < v.n && i < addr_log.size(); i++)
      chk($sformatf("v%0d addr%0d", idx, i), 32'(addr_log[i]), 32'(v.addrs[8*i +: 8]));
    chk($sformatf("v%0d n_data", idx), 32'(data_log.size()), 32'(v.n));
    for (int i = 0; i < v.n && i < data_log.size(); i++)
      chk($sformatf("v%0d data%0d", idx, i), 32'(data_log[i]), 32'(v.datas[8*i +: 8]));
    chk($sformatf("v%0d protocol", idx), 32'((v_addr - a0) + (v_hs - h0) + (v_hold - s0)), 32'd0);
    if (v.stall > 0) begin
`ifdef PIXEL_FETCH_PREFETCH_EN
      chk($sformatf("v%0d reqs_in_stall", idx), 32'(reqs_in_stall), 32'd1);
`else
      chk($sformatf("v%0d reqs_in_stall", idx), 32'(reqs_in_stall), 32'd0);
`endif
    end
    $display("frame v%0d base=0x%02h count=%0d: %0d bytes, done after %0d cycles",
             idx, v.base, v.count, data_log.size(), cyc);
  endtask

  initial begin
    int  h0, d0;
    bit  found;
    vecs[0] = mk(8'h10, 10'd3, 0,  0, -1, 0, 0, 3, 32'h00_12_11_10, 32'h00_B7_B4_B5);
    vecs[1] = mk(8'h33, 10'd0, 0,  0,  2, 0, 0, 0, 32'h0,           32'h0);
    vecs[2] = mk(8'hFE, 10'd4, 0,  0, -1, 0, 0, 4, 32'h01_00_FF_FE, 32'hA4_A5_5A_5B);
    vecs[3] = mk(8'h60, 10'd2, 0, 20, -1, 0, 0, 2, 32'h00_00_61_60, 32'h00_00_C4_C5);
    vecs[4] = mk(8'h40, 10'd2, 15, 0, -1, 0, 0, 2, 32'h00_00_41_40, 32'h00_00_E4_E5);
    vecs[5] = mk(8'h50, 10'd2, 0,  0, -1, 1, 1, 2, 32'h00_00_51_50, 32'h00_00_F4_F5);
    vecs[6] = mk(8'h30, 10'd1, 0,  0, -1, 0, 0, 1, 32'h00_00_00_30, 32'h00_00_00_95);

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset data_req", 32'(data_req), 32'd0);
    chk("reset data_addr", 32'(data_addr), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Reset while the second request of a frame is outstanding.
    h0 = hs_total; d0 = done_cnt; found = 0;
    base_addr = 8'h20; byte_count = 10'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (data_req && hs_total > h0) found = 1;
    end
    chk("rst setup req_pending", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst data_req", 32'(data_req), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst stays_idle", 32'({busy, data_req, out_valid}), 32'd0);
    $display("reset mid-frame applied after %0d bytes", hs_total - h0);

    run_frame(vecs[6], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
